// File: rtl/bayer_raw_if.sv
// bayer_raw_if: raw Bayer pixel stream (data, valid, start/end-of-packet flags)
interface bayer_raw_if #(parameter int DATA_WIDTH = 16);
  logic [DATA_WIDTH-1:0] raw_data;
  logic                  raw_valid;
  logic                  raw_sop;
  logic                  raw_eop;
  modport master(output raw_data, raw_valid, raw_sop, raw_eop);
  modport slave(input raw_data, raw_valid, raw_sop, raw_eop);
endinterface

// File: rtl/bayer_raw_source.sv
// bayer_raw_source: frame generator with blanking, test patterns, pedestal and defect injection
// Outputs are registered from next-state values so the first pixel appears one cycle after start.
module bayer_raw_source #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_enable_i,
  input  logic [12:0]           cfg_width_i,
  input  logic [12:0]           cfg_height_i,
  input  logic [7:0]            cfg_hblank_i,
  input  logic [15:0]           cfg_vblank_i,
  input  logic [1:0]            cfg_pattern_i,
  input  logic [DATA_WIDTH-1:0] cfg_solid_i,
  input  logic [7:0]            cfg_pedestal_i,
  input  logic                  cfg_defect_en_i,
  input  logic [12:0]           cfg_defect_x_i,
  input  logic [12:0]           cfg_defect_y_i,
  input  logic [DATA_WIDTH-1:0] cfg_defect_val_i,
  bayer_raw_if.master           raw,
  output logic                  frame_done_o,
  output logic [15:0]           frame_count_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
  typedef struct packed {
    logic [12:0]           w;
    logic [12:0]           h;
    logic [7:0]            hb;
    logic [15:0]           vb;
    logic [1:0]            pat;
    logic [DATA_WIDTH-1:0] solid;
    logic [7:0]            ped;
    logic                  den;
    logic [12:0]           dx;
    logic [12:0]           dy;
    logic [DATA_WIDTH-1:0] dval;
  } cfg_t;
  state_t                state_q, state_d;
  cfg_t                  cfg_in, cfg_q, cfg_d;
  logic [12:0]           x_q, x_d, y_q, y_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  load, done_d, start_ok, last_x, last_y, active_d;
  logic [DATA_WIDTH-1:0] bayer, base, pix;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, sop_q, eop_q, done_q, busy_q;
  logic [15:0]           count_q;
  assign cfg_in = '{w: cfg_width_i, h: cfg_height_i, hb: cfg_hblank_i, vb: cfg_vblank_i,
                    pat: cfg_pattern_i, solid: cfg_solid_i, ped: cfg_pedestal_i,
                    den: cfg_defect_en_i, dx: cfg_defect_x_i, dy: cfg_defect_y_i,
                    dval: cfg_defect_val_i};
  assign start_ok = cfg_enable_i && |cfg_width_i && |cfg_height_i;
  assign last_x   = x_q == cfg_q.w - 13'd1;
  assign last_y   = y_q == cfg_q.h - 13'd1;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (!last_x) begin
          x_d = x_q + 13'd1;
        end else if (!last_y) begin
          x_d = '0;
          if (cfg_q.hb == 8'd0) begin
            y_d = y_q + 13'd1;
          end else begin
            state_d = HBLANK;
            cnt_d   = 16'(cfg_q.hb);
          end
        end else begin
          done_d = 1'b1;
          x_d    = '0;
          y_d    = '0;
          if (cfg_q.vb != 16'd0) begin
            state_d = VBLANK;
            cnt_d   = cfg_q.vb;
          end else begin
            state_d = start_ok ? ACTIVE : IDLE;
            load    = start_ok;
          end
        end
      end
      HBLANK: begin
        if (cnt_q == 16'd1) begin
          state_d = ACTIVE;
          y_d     = y_q + 13'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      VBLANK: begin
        if (cnt_q == 16'd1) begin
          state_d = start_ok ? ACTIVE : IDLE;
          x_d     = '0;
          y_d     = '0;
          load    = start_ok;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // a frame starting this edge must see the live config, not the stale latch
  always_comb begin
    cfg_d    = load ? cfg_in : cfg_q;
    active_d = state_d == ACTIVE;
    bayer    = {y_d[0], x_d[0]} == 2'b00 ? DATA_WIDTH'(16'h0C00) :
               {y_d[0], x_d[0]} == 2'b11 ? DATA_WIDTH'(16'h0400) : DATA_WIDTH'(16'h0800);
    base     = cfg_d.pat == 2'd0 ? cfg_d.solid :
               cfg_d.pat == 2'd1 ? DATA_WIDTH'(x_d) :
               cfg_d.pat == 2'd2 ? bayer : {DATA_WIDTH{x_d[3] ^ y_d[3]}};
    sum      = {1'b0, base} + (DATA_WIDTH+1)'(cfg_d.ped);
    pix      = (cfg_d.den && x_d == cfg_d.dx && y_d == cfg_d.dy) ? cfg_d.dval :
               sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      data_q  <= active_d ? pix : '0;
      valid_q <= active_d;
      sop_q   <= active_d && x_d == 13'd0 && y_d == 13'd0;
      eop_q   <= active_d && x_d == cfg_d.w - 13'd1;
      done_q  <= done_d;
      busy_q  <= state_d != IDLE;
      count_q <= count_q + 16'(done_d);
    end
  end
  assign raw.raw_data  = data_q;
  assign raw.raw_valid = valid_q;
  assign raw.raw_sop   = sop_q;
  assign raw.raw_eop   = eop_q;
  assign frame_done_o  = done_q;
  assign frame_count_o = count_q;
  assign busy_o        = busy_q;
endmodule
